// File: rtl/dac_sample_fifo_if.sv
// Valid/ready sample channel used on both sides of the DAC sample FIFO.
interface dac_sample_fifo_if #(parameter int DATA_W = 16);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dac_sample_fifo.sv
// FWFT sample FIFO feeding the AD5541A driver, with a prefill gate that re-arms on underrun.
// Define DAC_FIFO_UNDERRUN_CNT_EN to add the saturating underrun_cnt port and counter.
module dac_sample_fifo #(
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8,
  parameter int DATA_W  = 16
) (
  input  logic                     mclk,
  input  logic                     rst_n,
  input  logic                     en,
  dac_sample_fifo_if.slave         s_axis,
  dac_sample_fifo_if.master        m_axis,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun
`ifdef DAC_FIFO_UNDERRUN_CNT_EN
  ,
  output logic [15:0]              underrun_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL    = LW'(DEPTH);
  localparam logic [LW-1:0] PREFILL_LEVEL = LW'(PREFILL);

  typedef enum logic {FILL, RUN} state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              underrun_det;

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);

  // Ready is held low while in reset so nothing lands in the cycle reset is asserted.
  assign s_axis.ready = rst_n && !full;
  assign push         = s_axis.valid && s_axis.ready;
  assign m_axis.valid = (state == RUN) && !empty;
  assign pop          = m_axis.valid && m_axis.ready;
  assign m_axis.data  = mem[rd_ptr];

  always_comb begin
    state_next   = state;
    underrun_det = 1'b0;
    case (state)
      FILL: begin
        if (en && level >= PREFILL_LEVEL) state_next = RUN;
      end
      RUN: begin
        if (m_axis.ready && empty) begin
          underrun_det = 1'b1;
          state_next   = FILL;
        end else if (!en) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      underrun <= 1'b0;
    end else begin
      state    <= state_next;
      underrun <= underrun_det;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge mclk) begin
    if (push) mem[wr_ptr] <= s_axis.data;
  end

`ifdef DAC_FIFO_UNDERRUN_CNT_EN
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (underrun_det && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
`endif

endmodule
